dcache_data_buffer: RTL and testbench
=====================================

Name: dcache_data_buffer

Overview:
- Parametrised data holding buffer for the dcache response path.
- Decouples the producer (data array / refill read) from a consumer that can stall.
- Generalises single-entry hold behaviour to DEPTH entries with a full valid/ready handshake on both sides.
- Adds synchronous flush, an occupancy count, and a selectable idle-output mode. Sits between the dcache data read stage and the load-return pipe.

Parameters:
- DATA_WIDTH, 32: width of each data word.
- DEPTH, 4: number of entries; a power of two, minimum 2.
- HOLD_LAST, 0: output value when empty. 0 drives zero; 1 holds the last popped word.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous clear of all stored entries
- in_valid  input  1  producer presents in_data
- in_ready  output  1  buffer can accept a word this cycle
- in_data  input  DATA_WIDTH  producer data
- out_valid  output  1  out_data holds a stored word
- out_ready  input  1  consumer accepts out_data this cycle
- out_data  output  DATA_WIDTH  head-of-buffer data
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

Behaviour:
- One clock domain.
- Reset is asynchronous and active-high. Reset clears wr_ptr, rd_ptr, count and the last-data register to 0. Storage array contents are not reset.
- Reset values:
  - in_ready = 1
  - out_valid = 0
  - out_data = 0
  - count = 0
- Handshake rules:
  - Push occurs when in_valid & in_ready.
  - Pop occurs when out_valid & out_ready.
  - in_valid and out_ready are ignored when their matching ready/valid is low; they have no side effect.
- Flags and data:
  - in_ready = (count != DEPTH). It is independent of out_ready, so there is no combinational ready path.
  - out_valid = (count != 0).
  - out_data = mem[rd_ptr] when out_valid.
  - When empty: out_data = 0 if HOLD_LAST=0, else the last popped word (0 after reset or flush).
- Latency:
  - A word pushed in cycle N is visible on out_data/out_valid from cycle N+1.
  - There is no combinational in->out bypass.
- Stall hold: while out_valid=1 and out_ready=0, out_data and out_valid stay stable until the pop.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH with no special case.
  - count is kept explicitly: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Simultaneous push and pop:
  - Not full and not empty: both proceed, count unchanged, order preserved.
  - Empty: only a push is possible; the pushed word appears next cycle.
  - Full: in_ready=0, so only the pop occurs; a push becomes possible the following cycle.
- Flush:
  - Next edge: pointers and count go to 0 and the last-data register goes to 0.
  - Flush has priority over a same-cycle push and pop. Both are discarded, although the handshake signals may show as accepted.
  - in_ready is not gated by flush.
- Order: strict FIFO; no reordering or dropping except on flush.
- Overflow/underflow: cannot occur by construction. A bench assertion shall check that count never exceeds DEPTH.

Test Plan:
- Fill and drain:
  - Stimulus: DEPTH=4, push 0x11, 0x22, 0x33, 0x44 with out_ready=0.
  - Required: count=4, in_ready=0. Then out_ready=1 for 4 cycles pops 0x11, 0x22, 0x33, 0x44 in order; count reaches 0 and out_valid=0.
- Stall hold:
  - Stimulus: push 0xA5, hold out_ready=0 for 5 cycles, then assert it.
  - Required: out_data=0xA5 and out_valid=1 stable throughout; a single pop follows.
- Streaming with wrap:
  - Stimulus: in_valid=1 and out_ready=1 continuously for 10 cycles with data 1..10.
  - Required: outputs 1..10, each one cycle after its push; count ≤1; pointers wrap past 3.
- Full plus simultaneous pop:
  - Stimulus: fill to 4, then in_valid=1 (data 0x55) and out_ready=1.
  - Required: 0x55 is not accepted that cycle, count drops to 3. Next cycle 0x55 is accepted and count=4.
- Flush:
  - Stimulus: with count=3, assert flush together with a push of 0x77 and a pop.
  - Required: next cycle count=0, out_valid=0, out_data=0; 0x77 never appears.
- Idle output modes:
  - HOLD_LAST=1: push 0xDEAD, then pop it. Required: out_data stays 0xDEAD while empty.
  - HOLD_LAST=0: same stimulus. Required: out_data=0.
  - Mid-stream async reset: required to clear all outputs immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dcache_data_buffer.sv
// Multi-entry data holding buffer between the dcache data read stage and the load-return pipe.
// It uses a valid/ready handshake on both sides, a synchronous flush, and a selectable output value while empty.
module dcache_data_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned HOLD_LAST  = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] lastData_q, lastData_d;
    logic                  push;
    logic                  pop;

    // Ready depends only on occupancy, so no combinational path runs from out_ready to in_ready.
    assign in_ready  = (count_q != FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign count     = count_q;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        if (out_valid) begin
            out_data = mem_q[rdPtr_q];
        end else if (HOLD_LAST != 0) begin
            out_data = lastData_q;
        end else begin
            out_data = '0;
        end
    end

    // Flush overrides any handshake that coincides with it.
    // Both pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        count_d    = count_q;
        lastData_d = lastData_q;
        if (flush) begin
            wrPtr_d    = '0;
            rdPtr_d    = '0;
            count_d    = '0;
            lastData_d = '0;
        end else begin
            if (push) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_d    = rdPtr_q + PTR_W'(1);
                lastData_d = mem_q[rdPtr_q];
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Storage has no reset. A write during flush is harmless because the pointers return to zero.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wrPtr_q] <= in_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            lastData_q <= '0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            lastData_q <= lastData_d;
        end
    end

endmodule

// File: tb/tb_dcache_data_buffer.sv
// Directed scoreboard bench for dcache_data_buffer.
// Two instances, HOLD_LAST=0 and HOLD_LAST=1, share every input and differ only in their idle output.
module tb_dcache_data_buffer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        inValid = 1'b0;
    logic [31:0] inData = '0;
    logic        outReady = 1'b0;

    logic        inReadyZero, outValidZero;
    logic [31:0] outDataZero;
    logic [2:0]  countZero;
    logic        inReadyHold, outValidHold;
    logic [31:0] outDataHold;
    logic [2:0]  countHold;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] expQ [$];

    dcache_data_buffer #(.DATA_WIDTH(32), .DEPTH(4), .HOLD_LAST(0)) dutZero (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(inValid), .in_ready(inReadyZero), .in_data(inData),
        .out_valid(outValidZero), .out_ready(outReady), .out_data(outDataZero),
        .count(countZero)
    );

    dcache_data_buffer #(.DATA_WIDTH(32), .DEPTH(4), .HOLD_LAST(1)) dutHold (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(inValid), .in_ready(inReadyHold), .in_data(inData),
        .out_valid(outValidHold), .out_ready(outReady), .out_data(outDataHold),
        .count(countHold)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Inputs change 2ns after a rising edge. The call returns 2ns after the edge that consumed them.
    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r, input logic f);
        inValid  = v;
        inData   = d;
        outReady = r;
        flush    = f;
        @(posedge clock);
        #2;
    endtask

    task automatic checkState(input string tag, input int cnt, input logic rdy, input logic vld,
                              input logic [31:0] dZero, input logic [31:0] dHold);
        checkOutput({tag, ".count"}, 32'(countZero), 32'(cnt));
        checkOutput({tag, ".inReady"}, 32'(inReadyZero), 32'(rdy));
        checkOutput({tag, ".outValid"}, 32'(outValidZero), 32'(vld));
        checkOutput({tag, ".outDataZero"}, outDataZero, dZero);
        checkOutput({tag, ".outDataHold"}, outDataHold, dHold);
    endtask

    // The monitor samples on the falling edge, where the inputs for the next rising edge are already stable.
    always @(negedge clock) begin
        if (!reset && !flush && outValidZero && outReady) begin
            if (expQ.size() == 0) begin
                miscompares++;
                vectors++;
                $display("[TB] FAIL unexpectedPop: got 0x%0h, expected no pop", outDataZero);
            end else begin
                logic [31:0] expWord;
                expWord = expQ.pop_front();
                checkOutput("popDataZero", outDataZero, expWord);
                checkOutput("popDataHold", outDataHold, expWord);
            end
        end
    end

    always @(negedge clock) begin
        assert (countZero <= 3'd4 && countHold <= 3'd4)
        else begin
            miscompares++;
            $display("[TB] FAIL countBound: got %0d/%0d, expected <= 4", countZero, countHold);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #12;
        checkState("reset", 0, 1'b1, 1'b0, 32'h0, 32'h0);
        @(posedge clock);
        #2;
        reset = 1'b0;

        // Fill and drain
        for (int i = 1; i <= 4; i++) begin
            expQ.push_back(32'(i * 32'h11));
            applyStimulus(1'b1, 32'(i * 32'h11), 1'b0, 1'b0);
        end
        checkState("full", 4, 1'b0, 1'b1, 32'h11, 32'h11);
        repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkState("drained", 0, 1'b1, 1'b0, 32'h0, 32'h44);

        // Stall hold
        expQ.push_back(32'hA5);
        applyStimulus(1'b1, 32'hA5, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
            checkState("stall", 1, 1'b1, 1'b1, 32'hA5, 32'hA5);
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkState("stallPop", 0, 1'b1, 1'b0, 32'h0, 32'hA5);

        // Streaming with wrap
        for (int i = 1; i <= 10; i++) begin
            expQ.push_back(32'(i));
            applyStimulus(1'b1, 32'(i), 1'b1, 1'b0);
            checkOutput("streamCount", 32'(countZero), 32'd1);
            checkOutput("streamHead", outDataZero, 32'(i));
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkState("streamEnd", 0, 1'b1, 1'b0, 32'h0, 32'd10);

        // Full plus simultaneous pop
        for (int i = 1; i <= 4; i++) begin
            expQ.push_back(32'h60 + 32'(i));
            applyStimulus(1'b1, 32'h60 + 32'(i), 1'b0, 1'b0);
        end
        expQ.push_back(32'h55);
        applyStimulus(1'b1, 32'h55, 1'b1, 1'b0);
        checkState("fullPop", 3, 1'b1, 1'b1, 32'h62, 32'h62);
        applyStimulus(1'b1, 32'h55, 1'b0, 1'b0);
        checkState("fullRetry", 4, 1'b0, 1'b1, 32'h62, 32'h62);
        repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkState("fullDrain", 0, 1'b1, 1'b0, 32'h0, 32'h55);

        // Flush with a same-cycle push and pop
        for (int i = 1; i <= 3; i++) begin
            expQ.push_back(32'h80 + 32'(i));
            applyStimulus(1'b1, 32'h80 + 32'(i), 1'b0, 1'b0);
        end
        checkOutput("preFlushCount", 32'(countZero), 32'd3);
        expQ.delete();
        applyStimulus(1'b1, 32'h77, 1'b1, 1'b1);
        checkState("flush", 0, 1'b1, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkState("postFlush", 0, 1'b1, 1'b0, 32'h0, 32'h0);

        // Idle output modes
        expQ.push_back(32'hDEAD);
        applyStimulus(1'b1, 32'hDEAD, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checkState("idleMode", 0, 1'b1, 1'b0, 32'h0, 32'hDEAD);
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        end

        // Mid-stream asynchronous reset
        applyStimulus(1'b1, 32'h91, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h92, 1'b0, 1'b0);
        checkState("preReset", 2, 1'b1, 1'b1, 32'h91, 32'h91);
        inValid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        checkState("asyncReset", 0, 1'b1, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkState("afterReset", 0, 1'b1, 1'b0, 32'h0, 32'h0);

        checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
